// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encoding, default word width and the parity helper.
package piso_tx_pkg;

  // Default data word width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Transmitter FSM states. ST_PAR is only entered when the parity
  // feature is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } tx_state_t;

  // Even parity over a zero-extended word: 1 when the word holds an odd
  // number of ones, so that word plus parity bit carries an even count.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Bit counter for the serial transmitter. Counts 0..WIDTH-1 while enabled,
// clear has priority over enable, and tc_o flags the last bit position.
// Asynchronous active-high reset.
module tx_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     tc_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance by one when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter. A WIDTH-bit word is accepted on a
// load_valid/load_ready handshake and shifted out one bit per clock on sdo,
// with frame_start on the first bit and done on the final bit of a frame.
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both 1. load_ready never depends on load_valid; it is 1 in
// IDLE and on the final bit of a frame (back-to-back reload), and 0 during
// reset. load_valid while load_ready=0 is ignored, never queued.
//
// Optional feature: define PARITY_BIT_EN to append one even-parity bit
// (computed at load) after the data bits; done and load_ready then move to
// that parity cycle.
module piso_serial_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  // Bit that leaves the word first for the configured bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  // Word after the head bit has been sent; vacated positions fill with 0.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             sdo_q;
  logic             sdo_d;

  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_en;

  logic             ready_c;
  logic             sdo_valid_c;
  logic             frame_start_c;
  logic             done_c;
  logic             hs;

`ifdef PARITY_BIT_EN
  logic             par_q;
`endif

  tx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // Ready is forced low while reset is held, without waiting for a clock.
  assign load_ready = ready_c & ~reset;
  assign hs         = load_valid & load_ready;

  // FSM next-state, datapath next values and frame strobes.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    sdo_d         = sdo_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    ready_c       = 1'b0;
    sdo_valid_c   = 1'b0;
    frame_start_c = 1'b0;
    done_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        sdo_d   = 1'b0;
      end

      ST_SHIFT: begin
        sdo_valid_c   = 1'b1;
        frame_start_c = (cnt == '0);
        if (cnt_tc) begin
          cnt_clr = 1'b1;
`ifdef PARITY_BIT_EN
          // Data bits finished; the parity bit follows on the next cycle.
          state_d = ST_PAR;
          sdo_d   = par_q;
`else
          ready_c = 1'b1;
          done_c  = 1'b1;
          state_d = ST_IDLE;
          sdo_d   = 1'b0;
`endif
        end else begin
          cnt_en  = 1'b1;
          sdo_d   = head_bit(shreg_q);
          shreg_d = shift_out(shreg_q);
        end
      end

`ifdef PARITY_BIT_EN
      ST_PAR: begin
        sdo_valid_c = 1'b1;
        done_c      = 1'b1;
        ready_c     = 1'b1;
        state_d     = ST_IDLE;
        sdo_d       = 1'b0;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        sdo_d   = 1'b0;
        shreg_d = '0;
        cnt_clr = 1'b1;
      end
    endcase

    // A handshake (from IDLE or on the final bit) starts a new frame: the
    // first bit goes straight to sdo and the remainder waits in shreg.
    if (hs) begin
      state_d = ST_SHIFT;
      sdo_d   = head_bit(load_data);
      shreg_d = shift_out(load_data);
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register and registered serial output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      sdo_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
    end
  end

`ifdef PARITY_BIT_EN
  // Parity of the captured word, latched at load time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (hs) begin
      par_q <= even_parity(32'(load_data));
    end
  end
`endif

  assign sdo         = sdo_q;
  assign sdo_valid   = sdo_valid_c;
  assign frame_start = frame_start_c;
  assign done        = done_c;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Testbench for piso_serial_tx: one LSB-first and one MSB-first instance,
// expected serial bits queued when a word is loaded and compared per cycle.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       reset;

  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       sdo;
  logic       sdo_valid;
  logic       frame_start;
  logic       done;

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_sdo;
  logic       m_sv;
  logic       m_fs;
  logic       m_done;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle entry: {sdo, frame_start, done, load_ready}.
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .sdo         (sdo),
    .sdo_valid   (sdo_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (m_valid),
    .load_ready  (m_ready),
    .load_data   (m_data),
    .sdo         (m_sdo),
    .sdo_valid   (m_sv),
    .frame_start (m_fs),
    .done        (m_done)
  );

  // ---------------- driver tasks ----------------
  // Queue the expected bit stream of one frame.
  task automatic push_frame(input logic [7:0] d, input bit msb);
    logic b;
    logic last;
    for (int i = 0; i < 8; i++) begin
      b = msb ? d[7-i] : d[i];
`ifdef PARITY_BIT_EN
      last = 1'b0;
`else
      last = (i == 7);
`endif
      exp_q.push_back({b, (i == 0), last, last});
    end
`ifdef PARITY_BIT_EN
    exp_q.push_back({^d, 1'b0, 1'b1, 1'b1});
`endif
  endtask

  // Handshake one word into an idle DUT, then scramble the data bus.
  task automatic start_frame(input logic [7:0] d, input bit msb);
    @(posedge clk); #1;
    if (msb) begin
      m_valid = 1'b1;
      m_data  = d;
    end else begin
      load_valid = 1'b1;
      load_data  = d;
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    m_valid    = 1'b0;
    load_data  = 8'($urandom_range(0, 255));
    m_data     = 8'($urandom_range(0, 255));
  endtask

  // Scoreboard: pop up to max entries, one per cycle, and compare.
  task automatic drain(input bit msb, input string tag, input int max);
    int n;
    logic [3:0] e;
    logic [3:0] o;
    logic v;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      @(negedge clk);
      n++;
      e = exp_q.pop_front();
      o = msb ? {m_sdo, m_fs, m_done, m_ready} : {sdo, frame_start, done, load_ready};
      v = msb ? m_sv : sdo_valid;
      checks++;
      if (v !== 1'b1 || o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: {valid,sdo,fs,done,ready} got %b%b required 1%b", tag, n, v, o, e);
      end
    end
  endtask

  task automatic check_idle(input bit msb, input string tag);
    logic [2:0] o;
    @(negedge clk);
    o = msb ? {m_sv, m_sdo, m_ready} : {sdo_valid, sdo, load_ready};
    checks++;
    if (o !== 3'b001) begin
      errors++;
      $display("FAIL %s idle: {valid,sdo,ready} got %b required 001", tag, o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [9:0] o;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    repeat (3) begin
      @(negedge clk);
      o = {load_ready, sdo, sdo_valid, frame_start, done, m_ready, m_sdo, m_sv, m_fs, m_done};
      checks++;
      if (o !== 10'b0) begin
        errors++;
        $display("FAIL reset outputs: got %b required 0000000000", o);
      end
    end
    reset = 1'b0;
    repeat (5) begin
      check_idle(1'b0, "post_reset_lsb");
      check_idle(1'b1, "post_reset_msb");
    end
  endtask

  task automatic test_single_frame;
    push_frame(8'hA5, 1'b0);
    start_frame(8'hA5, 1'b0);
    drain(1'b0, "lsb_A5", 20);
    check_idle(1'b0, "lsb_A5");
  endtask

  task automatic test_msb_first;
    push_frame(8'hA5, 1'b1);
    start_frame(8'hA5, 1'b1);
    drain(1'b1, "msb_A5", 20);
    push_frame(8'hC1, 1'b1);
    start_frame(8'hC1, 1'b1);
    drain(1'b1, "msb_C1", 20);
    check_idle(1'b1, "msb_C1");
  endtask

  task automatic test_back_to_back;
    push_frame(8'hFF, 1'b0);
    push_frame(8'h00, 1'b0);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(posedge clk); #1;
    load_data  = 8'h00;
    fork
      begin
`ifdef PARITY_BIT_EN
        repeat (9) @(posedge clk);
`else
        repeat (8) @(posedge clk);
`endif
        #1;
        load_valid = 1'b0;
        load_data  = 8'($urandom_range(0, 255));
      end
      drain(1'b0, "b2b", 40);
    join
    check_idle(1'b0, "b2b");
  endtask

  task automatic test_reset_mid_frame;
    logic [4:0] o;
    push_frame(8'hF0, 1'b0);
    start_frame(8'hF0, 1'b0);
    drain(1'b0, "mid_F0", 5);
    #1 reset = 1'b1;
    #1;
    o = {sdo, sdo_valid, frame_start, done, load_ready};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: {sdo,valid,fs,done,ready} got %b required 00000", o);
    end
    exp_q.delete();
    @(negedge clk);
    o = {sdo, sdo_valid, frame_start, done, load_ready};
    checks++;
    if (o !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_held: {sdo,valid,fs,done,ready} got %b required 00000", o);
    end
    reset = 1'b0;
    check_idle(1'b0, "after_mid_reset");
    push_frame(8'h01, 1'b0);
    start_frame(8'h01, 1'b0);
    drain(1'b0, "post_reset_01", 20);
    check_idle(1'b0, "post_reset_01");
  endtask

`ifdef PARITY_BIT_EN
  task automatic test_parity;
    push_frame(8'h07, 1'b0);
    start_frame(8'h07, 1'b0);
    drain(1'b0, "par_07", 20);
    push_frame(8'h03, 1'b0);
    start_frame(8'h03, 1'b0);
    drain(1'b0, "par_03", 20);
    check_idle(1'b0, "par");
  endtask
`endif

  task automatic test_random;
    logic [7:0] d;
    bit msb;
    for (int k = 0; k < 6; k++) begin
      d   = 8'($urandom_range(0, 255));
      msb = k[0];
      push_frame(d, msb);
      start_frame(d, msb);
      drain(msb, "random", 20);
    end
    check_idle(1'b0, "random_lsb");
    check_idle(1'b1, "random_msb");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_single_frame;
    test_msb_first;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef PARITY_BIT_EN
    test_parity;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
